// File: rtl/store_queue_if.sv
// Store queue port bundle: dispatch allocation, store execute, load lookup,
// retire handshake and the registered cache write port.
interface store_queue_if;
    logic        alloc_en;
    logic [3:0]  tail_ptr;
    logic        full;

    logic        exec_valid;
    logic [3:0]  exec_ptr;
    logic [31:0] exec_addr;
    logic [3:0]  exec_usebytes;
    logic [31:0] exec_data;

    logic [31:0] ld_addr;
    logic [3:0]  ld_tail_pos;
    logic [3:0]  fwd_usebytes;
    logic [31:0] fwd_data;
    logic        fwd_stall;

    logic        retire_en;
    logic        head_ready;
    logic        squash;

    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [3:0]  mem_usebytes;
    logic [31:0] mem_data;

    modport slave (
        input  alloc_en,
        output tail_ptr,
        output full,
        input  exec_valid,
        input  exec_ptr,
        input  exec_addr,
        input  exec_usebytes,
        input  exec_data,
        input  ld_addr,
        input  ld_tail_pos,
        output fwd_usebytes,
        output fwd_data,
        output fwd_stall,
        input  retire_en,
        output head_ready,
        input  squash,
        output mem_wr_en,
        output mem_addr,
        output mem_usebytes,
        output mem_data
    );

    modport master (
        output alloc_en,
        input  tail_ptr,
        input  full,
        output exec_valid,
        output exec_ptr,
        output exec_addr,
        output exec_usebytes,
        output exec_data,
        output ld_addr,
        output ld_tail_pos,
        input  fwd_usebytes,
        input  fwd_data,
        input  fwd_stall,
        output retire_en,
        input  head_ready,
        output squash,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_usebytes,
        input  mem_data
    );
endinterface

// File: rtl/store_queue.sv
// Eight-entry store queue: holds in-flight stores, forwards bytes to younger
// loads and drains retired stores in order to a registered cache write port.
module store_queue (
    input logic          clock,
    input logic          reset,
    store_queue_if.slave sq
);
    localparam int SQ_DEPTH = 8;
    localparam int IDXW     = 3;
    localparam int PTRW     = IDXW + 1;

    logic [PTRW-1:0]     head_q, head_d;
    logic [PTRW-1:0]     tail_q, tail_d;
    logic [PTRW-1:0]     count_q, count_d;
    logic [SQ_DEPTH-1:0] addr_valid_q, addr_valid_d;
    logic [29:0]         addr_q [SQ_DEPTH];
    logic [29:0]         addr_d [SQ_DEPTH];
    logic [3:0]          usebytes_q [SQ_DEPTH];
    logic [3:0]          usebytes_d [SQ_DEPTH];
    logic [31:0]         data_q [SQ_DEPTH];
    logic [31:0]         data_d [SQ_DEPTH];

    logic                mem_wr_en_q, mem_wr_en_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [3:0]          mem_usebytes_q, mem_usebytes_d;
    logic [31:0]         mem_data_q, mem_data_d;

    logic                full;
    logic                head_ready;
    logic                do_alloc;
    logic                do_retire;
    logic [IDXW-1:0]     head_idx;
    logic [IDXW-1:0]     tail_idx;
    logic [IDXW-1:0]     exec_idx;

    logic [PTRW-1:0]     older_cnt;
    logic [IDXW-1:0]     lk_idx;
    logic                lk_stall;
    logic [3:0]          lk_usebytes;
    logic [31:0]         lk_data;

    // Word-granular storage: the byte offset bits and the exec pointer wrap
    // bit carry no information inside the queue.
    logic                unused_bits;
    assign unused_bits = ^{sq.exec_ptr[PTRW-1], sq.exec_addr[1:0], sq.ld_addr[1:0]};

    always_comb begin
        head_idx   = head_q[IDXW-1:0];
        tail_idx   = tail_q[IDXW-1:0];
        exec_idx   = sq.exec_ptr[IDXW-1:0];
        full       = (count_q == PTRW'(SQ_DEPTH));
        head_ready = (count_q != '0) && addr_valid_q[head_idx];
        do_retire  = sq.retire_en && head_ready;
        do_alloc   = sq.alloc_en && !full && !sq.squash;
    end

    always_comb begin
        head_d         = do_retire ? head_q + PTRW'(1) : head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        addr_valid_d   = addr_valid_q;
        addr_d         = addr_q;
        usebytes_d     = usebytes_q;
        data_d         = data_q;
        mem_wr_en_d    = do_retire;
        mem_addr_d     = mem_addr_q;
        mem_usebytes_d = mem_usebytes_q;
        mem_data_d     = mem_data_q;

        if (do_retire) begin
            mem_addr_d     = {addr_q[head_idx], 2'b00};
            mem_usebytes_d = usebytes_q[head_idx];
            mem_data_d     = data_q[head_idx];
        end

        // A squash still lets the head retire, then empties behind it.
        if (sq.squash) begin
            tail_d       = head_d;
            count_d      = '0;
            addr_valid_d = '0;
        end else begin
            if (do_alloc) begin
                addr_valid_d[tail_idx] = 1'b0;
                tail_d                 = tail_q + PTRW'(1);
            end
            if (sq.exec_valid) begin
                addr_valid_d[exec_idx] = 1'b1;
                addr_d[exec_idx]       = sq.exec_addr[31:2];
                usebytes_d[exec_idx]   = sq.exec_usebytes;
                data_d[exec_idx]       = sq.exec_data;
            end
            count_d = count_q + PTRW'(do_alloc) - PTRW'(do_retire);
        end
    end

    // Walk from oldest to youngest so the youngest matching store wins each
    // lane; entries beyond the live count never take part.
    always_comb begin
        older_cnt   = sq.ld_tail_pos - head_q;
        lk_idx      = head_idx;
        lk_stall    = 1'b0;
        lk_usebytes = '0;
        lk_data     = '0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            lk_idx = head_idx + IDXW'(k);
            if ((PTRW'(k) < older_cnt) && (PTRW'(k) < count_q)) begin
                if (!addr_valid_q[lk_idx]) begin
                    lk_stall = 1'b1;
                end else if (addr_q[lk_idx] == sq.ld_addr[31:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (usebytes_q[lk_idx][b]) begin
                            lk_usebytes[b]    = 1'b1;
                            lk_data[8*b +: 8] = data_q[lk_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
        if (lk_stall) begin
            lk_usebytes = '0;
            lk_data     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            addr_valid_q   <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_usebytes_q <= '0;
            mem_data_q     <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                addr_q[i]     <= '0;
                usebytes_q[i] <= '0;
                data_q[i]     <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            addr_valid_q   <= addr_valid_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_usebytes_q <= mem_usebytes_d;
            mem_data_q     <= mem_data_d;
            addr_q         <= addr_d;
            usebytes_q     <= usebytes_d;
            data_q         <= data_d;
        end
    end

    assign sq.tail_ptr     = tail_q;
    assign sq.full         = full;
    assign sq.head_ready   = head_ready;
    assign sq.fwd_stall    = lk_stall;
    assign sq.fwd_usebytes = lk_usebytes;
    assign sq.fwd_data     = lk_data;
    assign sq.mem_wr_en    = mem_wr_en_q;
    assign sq.mem_addr     = mem_addr_q;
    assign sq.mem_usebytes = mem_usebytes_q;
    assign sq.mem_data     = mem_data_q;
endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed lookup table, multi-cycle
// corner sequences, and randomized traffic against a queue-level model.
module tb_store_queue;
    logic clock;
    logic reset;
    store_queue_if sqi ();

    store_queue dut (.clock(clock), .reset(reset), .sq(sqi.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue bookkeeping with integer pointers.
    int          m_head, m_tail, m_count;
    bit          m_valid [8];
    logic [31:0] m_addr  [8];
    logic [3:0]  m_ub    [8];
    logic [31:0] m_data  [8];
    bit          m_wr;
    logic [31:0] m_maddr, m_mdata;
    logic [3:0]  m_mub;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  tp;
        logic        stall;
        logic [3:0]  ub;
        logic [31:0] data;
    } lk_vec_t;

    lk_vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit ret, alc;
        int h, e;
        if (reset) begin
            m_head = 0; m_tail = 0; m_count = 0;
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            m_wr = 1'b0; m_maddr = '0; m_mub = '0; m_mdata = '0;
            return;
        end
        ret = sqi.retire_en && (m_count > 0) && m_valid[m_head % 8];
        alc = sqi.alloc_en && (m_count < 8);
        m_wr = ret;
        if (ret) begin
            h = m_head % 8;
            m_maddr = m_addr[h] & 32'hFFFF_FFFC;
            m_mub   = m_ub[h];
            m_mdata = m_data[h];
            m_head  = (m_head + 1) % 16;
            m_count = m_count - 1;
        end
        if (sqi.squash) begin
            m_tail = m_head;
            m_count = 0;
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        end else begin
            if (alc) begin
                m_valid[m_tail % 8] = 1'b0;
                m_tail = (m_tail + 1) % 16;
                m_count = m_count + 1;
            end
            if (sqi.exec_valid) begin
                e = int'(sqi.exec_ptr) % 8;
                m_valid[e] = 1'b1;
                m_addr[e]  = sqi.exec_addr;
                m_ub[e]    = sqi.exec_usebytes;
                m_data[e]  = sqi.exec_data;
            end
        end
    endtask

    function automatic void model_lookup(input logic [31:0] la, input logic [3:0] tp,
                                         output bit st, output logic [3:0] ub,
                                         output logic [31:0] d);
        int n, p;
        n = (int'(tp) - m_head + 16) % 16;
        if (n > m_count) n = m_count;
        st = 1'b0; ub = '0; d = '0;
        for (int j = 0; j < n; j++)
            if (!m_valid[(m_head + j) % 8]) st = 1'b1;
        if (st) return;
        for (int lane = 0; lane < 4; lane++) begin
            for (int j = n - 1; j >= 0; j--) begin
                p = (m_head + j) % 8;
                if (m_addr[p][31:2] == la[31:2] && m_ub[p][lane]) begin
                    ub[lane] = 1'b1;
                    d[lane*8 +: 8] = m_data[p][lane*8 +: 8];
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        bit st;
        logic [3:0] ub;
        logic [31:0] d;
        model_lookup(sqi.ld_addr, sqi.ld_tail_pos, st, ub, d);
        chk({tag, ".tail_ptr"},   32'(sqi.tail_ptr),     32'(m_tail));
        chk({tag, ".full"},       32'(sqi.full),         32'(m_count == 8));
        chk({tag, ".head_ready"}, 32'(sqi.head_ready),   32'((m_count > 0) && m_valid[m_head % 8]));
        chk({tag, ".mem_wr_en"},  32'(sqi.mem_wr_en),    32'(m_wr));
        chk({tag, ".mem_addr"},   sqi.mem_addr,          m_maddr);
        chk({tag, ".mem_ub"},     32'(sqi.mem_usebytes), 32'(m_mub));
        chk({tag, ".mem_data"},   sqi.mem_data,          m_mdata);
        chk({tag, ".fwd_stall"},  32'(sqi.fwd_stall),    32'(st));
        chk({tag, ".fwd_ub"},     32'(sqi.fwd_usebytes), 32'(ub));
        chk({tag, ".fwd_data"},   sqi.fwd_data,          d);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        sqi.alloc_en = 1'b0; sqi.exec_valid = 1'b0; sqi.exec_ptr = '0;
        sqi.exec_addr = '0; sqi.exec_usebytes = '0; sqi.exec_data = '0;
        sqi.ld_addr = '0; sqi.ld_tail_pos = '0;
        sqi.retire_en = 1'b0; sqi.squash = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        sqi.alloc_en = 1'b1;
        for (int i = 0; i < n; i++) tick();
        sqi.alloc_en = 1'b0;
    endtask

    task automatic exec_st(input logic [3:0] p, input logic [31:0] a,
                           input logic [3:0] ub, input logic [31:0] d);
        sqi.exec_valid = 1'b1; sqi.exec_ptr = p; sqi.exec_addr = a;
        sqi.exec_usebytes = ub; sqi.exec_data = d;
        tick();
        sqi.exec_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic [3:0] tp);
        sqi.ld_addr = a; sqi.ld_tail_pos = tp;
        #1;
    endtask

    task automatic chk_fwd(input string tag, input logic st, input logic [3:0] ub, input logic [31:0] d);
        chk({tag, ".stall"}, 32'(sqi.fwd_stall),    32'(st));
        chk({tag, ".ub"},    32'(sqi.fwd_usebytes), 32'(ub));
        chk({tag, ".data"},  sqi.fwd_data,          d);
    endtask

    initial begin
        vecs[0] = '{32'h100, 4'd1, 1'b0, 4'b0011, 32'h0000BEEF};
        vecs[1] = '{32'h200, 4'd3, 1'b0, 4'b1111, 32'h112233AA};
        vecs[2] = '{32'h200, 4'd2, 1'b0, 4'b1111, 32'h11223344};
        vecs[3] = '{32'h200, 4'd4, 1'b1, 4'b0000, 32'h00000000};
        vecs[4] = '{32'h200, 4'd0, 1'b0, 4'b0000, 32'h00000000};
        vecs[5] = '{32'h100, 4'd3, 1'b0, 4'b0011, 32'h0000BEEF};
        vecs[6] = '{32'h300, 4'd3, 1'b0, 4'b0000, 32'h00000000};
        vecs[7] = '{32'h200, 4'd1, 1'b0, 4'b0000, 32'h00000000};
        vecs[8] = '{32'h104, 4'd3, 1'b0, 4'b0000, 32'h00000000};

        reset = 1'b1;
        set_idle();
        tick();
        do_reset();

        // Reset state
        lookup(32'h100, 4'd5);
        chk("rst.tail_ptr", 32'(sqi.tail_ptr), 32'h0);
        chk("rst.full", 32'(sqi.full), 32'h0);
        chk("rst.head_ready", 32'(sqi.head_ready), 32'h0);
        chk("rst.mem_wr_en", 32'(sqi.mem_wr_en), 32'h0);
        chk_fwd("rst.fwd", 1'b0, 4'h0, 32'h0);
        check_outputs("rst");

        // Known state for the lookup table
        alloc_n(4);
        exec_st(4'd0, 32'h100, 4'b0011, 32'h0000BEEF);
        exec_st(4'd1, 32'h200, 4'b1111, 32'h11223344);
        exec_st(4'd2, 32'h200, 4'b0001, 32'h000000AA);
        chk("tbl.tail_ptr", 32'(sqi.tail_ptr), 32'h4);
        chk("tbl.head_ready", 32'(sqi.head_ready), 32'h1);
        for (int i = 0; i < 9; i++) begin
            lookup(vecs[i].addr, vecs[i].tp);
            chk_fwd($sformatf("vec%0d", i), vecs[i].stall, vecs[i].ub, vecs[i].data);
            check_outputs($sformatf("vec%0d.m", i));
        end

        // Older store with unknown address
        do_reset();
        alloc_n(2);
        exec_st(4'd1, 32'h200, 4'b1111, 32'h55667788);
        chk("unk.head_ready", 32'(sqi.head_ready), 32'h0);
        lookup(32'h200, 4'd2);
        chk_fwd("unk.tp2", 1'b1, 4'h0, 32'h0);
        lookup(32'h200, 4'd0);
        chk_fwd("unk.tp0", 1'b0, 4'h0, 32'h0);

        // Full queue, retire, wrap
        do_reset();
        alloc_n(8);
        for (int i = 0; i < 8; i++)
            exec_st(4'(i), 32'h400 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
        chk("full.full", 32'(sqi.full), 32'h1);
        chk("full.tail", 32'(sqi.tail_ptr), 32'h8);
        alloc_n(1);
        chk("full.ign_tail", 32'(sqi.tail_ptr), 32'h8);
        chk("full.ign_wr", 32'(sqi.mem_wr_en), 32'h0);
        sqi.retire_en = 1'b1;
        tick();
        sqi.retire_en = 1'b0;
        chk("ret.mem_wr_en", 32'(sqi.mem_wr_en), 32'h1);
        chk("ret.mem_addr", sqi.mem_addr, 32'h400);
        chk("ret.mem_ub", 32'(sqi.mem_usebytes), 32'hF);
        chk("ret.mem_data", sqi.mem_data, 32'hA000_0000);
        chk("ret.full", 32'(sqi.full), 32'h0);
        tick();
        chk("ret.pulse_end", 32'(sqi.mem_wr_en), 32'h0);
        alloc_n(1);
        chk("wrap.tail", 32'(sqi.tail_ptr), 32'h9);
        chk("wrap.full", 32'(sqi.full), 32'h1);
        lookup(32'h404, 4'd9);
        chk_fwd("wrap.unk", 1'b1, 4'h0, 32'h0);
        exec_st(4'h8, 32'h500, 4'b0011, 32'h0000CAFE);
        lookup(32'h500, 4'd9);
        chk_fwd("wrap.new", 1'b0, 4'b0011, 32'h0000CAFE);
        lookup(32'h404, 4'd9);
        chk_fwd("wrap.old", 1'b0, 4'hF, 32'hA000_0001);
        lookup(32'h400, 4'd9);
        chk_fwd("wrap.gone", 1'b0, 4'h0, 32'h0);
        check_outputs("wrap");

        // Squash, then retire with nothing ready
        do_reset();
        alloc_n(3);
        for (int i = 0; i < 3; i++)
            exec_st(4'(i), 32'h600, 4'hF, 32'h0B00_0000 + 32'(i));
        sqi.squash = 1'b1;
        tick();
        sqi.squash = 1'b0;
        chk("sq.head_ready", 32'(sqi.head_ready), 32'h0);
        chk("sq.full", 32'(sqi.full), 32'h0);
        chk("sq.tail", 32'(sqi.tail_ptr), 32'h0);
        lookup(32'h600, 4'd3);
        chk_fwd("sq.fwd", 1'b0, 4'h0, 32'h0);
        sqi.retire_en = 1'b1;
        tick();
        sqi.retire_en = 1'b0;
        chk("sq.no_wr", 32'(sqi.mem_wr_en), 32'h0);

        // Reset with live entries and concurrent requests
        do_reset();
        alloc_n(4);
        for (int i = 0; i < 4; i++)
            exec_st(4'(i), 32'h700 + 32'(4 * i), 4'hF, 32'hC000_0000 + 32'(i));
        sqi.retire_en = 1'b1;
        tick();
        chk("mid.mem_wr_en", 32'(sqi.mem_wr_en), 32'h1);
        reset = 1'b1; sqi.alloc_en = 1'b1; sqi.exec_valid = 1'b1;
        sqi.exec_ptr = 4'd1; sqi.exec_addr = 32'h704; sqi.exec_usebytes = 4'hF;
        tick();
        reset = 1'b0;
        set_idle();
        lookup(32'h704, 4'd4);
        chk("mid.tail", 32'(sqi.tail_ptr), 32'h0);
        chk("mid.full", 32'(sqi.full), 32'h0);
        chk("mid.head_ready", 32'(sqi.head_ready), 32'h0);
        chk("mid.mem_wr_en", 32'(sqi.mem_wr_en), 32'h0);
        chk("mid.mem_addr", sqi.mem_addr, 32'h0);
        chk("mid.mem_ub", 32'(sqi.mem_usebytes), 32'h0);
        chk("mid.mem_data", sqi.mem_data, 32'h0);
        chk_fwd("mid.fwd", 1'b0, 4'h0, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            sqi.alloc_en = $urandom_range(0, 1) == 1;
            sqi.exec_valid = (m_count > 0) && ($urandom_range(0, 1) == 1);
            sqi.exec_ptr = (m_count > 0) ? 4'((m_head + $urandom_range(0, m_count - 1)) % 16) : 4'd0;
            sqi.exec_addr = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            sqi.exec_usebytes = 4'($urandom);
            sqi.exec_data = $urandom;
            sqi.retire_en = $urandom_range(0, 9) < 4;
            sqi.squash = ($urandom_range(0, 39) == 0);
            sqi.ld_addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
            sqi.ld_tail_pos = ($urandom_range(0, 1) == 1)
                              ? 4'((m_head + $urandom_range(0, m_count)) % 16)
                              : 4'($urandom);
            #1;
            check_outputs("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
